// File: rtl/rgb565_gray_pipe.sv
// rgb565_gray_pipe
// Converts a captured RGB565 pixel stream into 8-bit luma for the Sobel
// stage, three clocks deep, and drops the first FRAME_DROP complete frames
// after reset while the sensor settles.
//
// Ports:
//   clk, rst_n                 pixel clock (cam_pclk), async active-low reset
//   in_frame_vsync/href/clken  capture timing strobes
//   in_img_rgb[15:0]           {R[4:0], G[5:0], B[4:0]}
//   out_frame_vsync/href/clken timing strobes, gated and delayed 3 clocks
//   out_img_Y[7:0]             luma, aligned with out_frame_clken
//   out_frame_err              sticky line/frame geometry error
//
// Build option: define GRAY_GEOM_CHECK_EN to build the pixel/line geometry
// checker; otherwise out_frame_err is tied low.
module rgb565_gray_pipe #(
  parameter int FRAME_DROP = 10,
  parameter int H_PIXEL    = 640,
  parameter int V_PIXEL    = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_frame_vsync,
  input  logic        in_frame_href,
  input  logic        in_frame_clken,
  input  logic [15:0] in_img_rgb,
  output logic        out_frame_vsync,
  output logic        out_frame_href,
  output logic        out_frame_clken,
  output logic [7:0]  out_img_Y,
  output logic        out_frame_err
);

  localparam int FCW = $clog2(FRAME_DROP + 2);
  localparam logic [FCW-1:0] LAST_DROP = FCW'(FRAME_DROP);
  localparam logic [FCW-1:0] PASS_EDGE = FCW'(FRAME_DROP + 1);

  if (FRAME_DROP < 0 || H_PIXEL < 1 || V_PIXEL < 1) begin : g_param_check
    $error("rgb565_gray_pipe: invalid FRAME_DROP/H_PIXEL/V_PIXEL");
  end

  // ---------------------------------------------------------------------
  // Frame counter and pass enable
  // ---------------------------------------------------------------------
  logic           vsync_d;
  logic [FCW-1:0] frame_cnt;
  logic           pass_en;
  logic           vsync_rise;
  logic           pass_now;

  assign vsync_rise = in_frame_vsync & ~vsync_d;
  // Enable takes effect in the very cycle that carries the passing edge.
  assign pass_now   = pass_en | (vsync_rise & (frame_cnt == LAST_DROP));

  // vsync_d resets high so a vsync already asserted when reset releases is
  // not mistaken for the start of a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d   <= 1'b1;
      frame_cnt <= '0;
      pass_en   <= 1'b0;
    end else begin
      vsync_d <= in_frame_vsync;
      if (vsync_rise && frame_cnt != PASS_EDGE)
        frame_cnt <= frame_cnt + FCW'(1);
      pass_en <= pass_now;
    end
  end

  logic vs_g, hs_g, ck_g;
  assign vs_g = in_frame_vsync & pass_now;
  assign hs_g = in_frame_href  & pass_now;
  assign ck_g = in_frame_clken & pass_now;

  // ---------------------------------------------------------------------
  // Luma pipeline: products -> rounded sum -> Y
  // ---------------------------------------------------------------------
  logic [7:0]  r8, g8, b8;
  logic [15:0] prod_r, prod_g, prod_b;
  logic [16:0] sum_s2;
  logic [7:0]  y_s3;
  logic [2:0]  sync_s1, sync_s2, sync_s3;

  assign r8 = {in_img_rgb[15:11], in_img_rgb[15:13]};
  assign g8 = {in_img_rgb[10:5],  in_img_rgb[10:9]};
  assign b8 = {in_img_rgb[4:0],   in_img_rgb[4:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= '0;
      prod_g  <= '0;
      prod_b  <= '0;
      sum_s2  <= '0;
      y_s3    <= '0;
      sync_s1 <= '0;
      sync_s2 <= '0;
      sync_s3 <= '0;
    end else begin
      prod_r  <= 16'(r8) * 16'd77;
      prod_g  <= 16'(g8) * 16'd150;
      prod_b  <= 16'(b8) * 16'd29;
      sum_s2  <= 17'(prod_r) + 17'(prod_g) + 17'(prod_b) + 17'd128;
      // Coefficients sum to 256 so the carry never sets; the select only
      // keeps the full-width sum honest.
      y_s3    <= sum_s2[16] ? 8'hFF : sum_s2[15:8];
      sync_s1 <= {vs_g, hs_g, ck_g};
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
    end
  end

  assign out_frame_vsync = sync_s3[2];
  assign out_frame_href  = sync_s3[1];
  assign out_frame_clken = sync_s3[0];
  assign out_img_Y       = y_s3;

  // ---------------------------------------------------------------------
  // Geometry check (runs on the gated strobes, so only while passing)
  // ---------------------------------------------------------------------
`ifdef GRAY_GEOM_CHECK_EN
  localparam int GEOM_MAX = (H_PIXEL > V_PIXEL) ? H_PIXEL : V_PIXEL;
  localparam int CW       = $clog2(GEOM_MAX + 2);

  logic [CW-1:0] pix_cnt, line_cnt, lines_done;
  logic          hs_g_d, vs_g_d, err_r;
  logic          href_fall, vs_g_rise;

  assign href_fall  = hs_g_d & ~hs_g;
  assign vs_g_rise  = vs_g & ~vs_g_d;
  // A line ending in the same cycle as the next vsync still belongs to
  // the frame being closed.
  assign lines_done = line_cnt + CW'(href_fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      hs_g_d   <= 1'b0;
      vs_g_d   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      hs_g_d <= hs_g;
      vs_g_d <= vs_g;
      if (href_fall) begin
        pix_cnt <= '0;
        if (pix_cnt != CW'(H_PIXEL)) err_r <= 1'b1;
      end else if (hs_g && ck_g && pix_cnt != '1) begin
        pix_cnt <= pix_cnt + CW'(1);
      end
      // pass_en is still low on the first passing edge: no frame to judge.
      if (vs_g_rise) begin
        line_cnt <= '0;
        if (pass_en && lines_done != CW'(V_PIXEL)) err_r <= 1'b1;
      end else if (href_fall && line_cnt != '1) begin
        line_cnt <= lines_done;
      end
    end
  end

  assign out_frame_err = err_r;
`else
  assign out_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rgb565_gray_pipe.sv
module tb_rgb565_gray_pipe;
  localparam int FD = 2;
  localparam int H  = 16;
  localparam int V  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ivs = 1'b0, ihs = 1'b0, ick = 1'b0;
  logic [15:0] ipx = '0;
  logic        ovs, ohs, ock, oerr;
  logic [7:0]  oy;

  rgb565_gray_pipe #(.FRAME_DROP(FD), .H_PIXEL(H), .V_PIXEL(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_frame_vsync(ivs), .in_frame_href(ihs), .in_frame_clken(ick),
    .in_img_rgb(ipx),
    .out_frame_vsync(ovs), .out_frame_href(ohs), .out_frame_clken(ock),
    .out_img_Y(oy), .out_frame_err(oerr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       ck;
    logic [7:0] y;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_edges, m_pix, m_lines, inc_val;
  bit m_prev_vs, m_prev_hg, m_prev_gv, m_was_pass, m_err;
  logic [15:0] bars [5] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic vs, input logic hs, input logic ck,
                                 input logic [15:0] px);
    exp_t e;
    int r, g, b, r8, g8, b8;
    bit pass, gv, gh, gc;
    r  = int'(px[15:11]);
    g  = int'(px[10:5]);
    b  = int'(px[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    if (vs && !m_prev_vs && m_edges < FD + 1) m_edges++;
    m_prev_vs = vs;
    pass = (m_edges >= FD + 1);
    gv = vs && pass;
    gh = hs && pass;
    gc = ck && pass;
    if (pass) begin
      if (m_prev_hg && !gh) begin
        m_lines++;
        if (m_pix != H) m_err = 1'b1;
        m_pix = 0;
      end
      if (gh && gc) m_pix++;
      if (gv && !m_prev_gv) begin
        if (m_was_pass && m_lines != V) m_err = 1'b1;
        m_lines = 0;
      end
    end
    m_prev_hg  = gh;
    m_prev_gv  = gv;
    m_was_pass = pass;
    e.vs = gv;
    e.hs = gh;
    e.ck = gc;
    e.y  = 8'((r8 * 77 + g8 * 150 + b8 * 29 + 128) / 256);
    return e;
  endfunction

  function automatic logic [15:0] pix(input int mode, input int i);
    case (mode)
      1:       return bars[i % 5];
      2:       return 16'(inc_val + i);
      default: return 16'($urandom);
    endcase
  endfunction

  // Check outputs owed by the input three steps back, then drive a new beat.
  task automatic step(input logic vs, input logic hs, input logic ck, input logic [15:0] px);
    exp_t e;
    @(negedge clk);
    e = q.pop_front();
    chk("vsync", 16'(ovs), 16'(e.vs));
    chk("href",  16'(ohs), 16'(e.hs));
    chk("clken", 16'(ock), 16'(e.ck));
    if (e.ck) chk("Y", 16'(oy), 16'(e.y));
`ifdef GRAY_GEOM_CHECK_EN
    chk("err", 16'(oerr), 16'(m_err));
`else
    chk("err", 16'(oerr), 16'h0);
`endif
    ivs = vs; ihs = hs; ick = ck; ipx = px;
    q.push_back(model(vs, hs, ck, px));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vsync"}, 16'(ovs), 16'h0);
    chk({tag, "_href"},  16'(ohs), 16'h0);
    chk({tag, "_clken"}, 16'(ock), 16'h0);
    chk({tag, "_Y"},     16'(oy),  16'h0);
    chk({tag, "_err"},   16'(oerr), 16'h0);
  endtask

  task automatic reset_phase(input int n);
    exp_t z;
    @(negedge clk);
    rst_n = 1'b0;
    ivs = 1'($urandom); ihs = 1'($urandom); ick = 1'($urandom); ipx = 16'($urandom);
    #1;
    check_zero("rst_async");
    repeat (n) begin
      @(negedge clk);
      ivs = 1'($urandom); ihs = 1'($urandom); ick = 1'($urandom); ipx = 16'($urandom);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    ivs = 1'b0; ihs = 1'b0; ick = 1'b0; ipx = '0;
    rst_n = 1'b1;
    m_edges = 0; m_pix = 0; m_lines = 0;
    m_prev_vs = 1'b0; m_prev_hg = 1'b0; m_prev_gv = 1'b0; m_was_pass = 1'b0; m_err = 1'b0;
    z = '0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    q.push_back(model(1'b0, 1'b0, 1'b0, 16'h0));
  endtask

  task automatic send_line(input int npix, input int mode, input bit gaps);
    int  sent;
    logic c;
    sent = 0;
    while (sent < npix) begin
      c = gaps ? 1'($urandom) : 1'b1;
      step(1'b0, 1'b1, c, c ? pix(mode, sent) : 16'($urandom));
      if (c) sent++;
    end
    if (mode == 2) inc_val += npix;
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic send_frame(input int nlines, input int npix, input int mode,
                            input bit gaps, input int short_at);
    repeat (2) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    repeat (2) step(1'b0, 1'b0, 1'b0, 16'($urandom));
    for (int l = 0; l < nlines; l++)
      send_line((l == short_at) ? npix - 1 : npix, mode, gaps);
  endtask

  initial begin
    inc_val = 0;
    // power-on reset with random inputs, then a partial frame in flight
    reset_phase(4);
    send_line(H, 0, 1'b1);
    send_line(H, 0, 1'b0);
    // frames 1-2 dropped, frame 3 onwards passes
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(V, H, 0, 1'b1, -1);
    send_frame(V, H, 1, 1'b0, -1);
    send_frame(V, H, 0, 1'b1, -1);
    send_frame(V, H, 2, 1'b0, -1);
    // short line, then correct frames
    send_frame(V, H, 0, 1'b0, 1);
    send_frame(V, H, 1, 1'b1, -1);
    // reset in the middle of an active line
    repeat (2) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    repeat (5) step(1'b0, 1'b1, 1'b1, 16'($urandom));
    reset_phase(3);
    send_line(H - 5, 0, 1'b0);
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(V, H, 1, 1'b0, -1);
    // short frame, flagged at the next vsync
    send_frame(V - 1, H, 0, 1'b1, -1);
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(0, H, 0, 1'b0, -1);
    // throughput: 640 back-to-back incrementing pixels
    reset_phase(2);
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(V, H, 0, 1'b0, -1);
    send_frame(1, 640, 2, 1'b0, -1);
    send_frame(0, H, 0, 1'b0, -1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rgb565_gray_pipe.md
# rgb565_gray_pipe

Pipelined RGB565-to-luma (Y) converter with start-up frame dropping. It sits between the CMOS capture stage and the Sobel image processor, on the `cam_pclk` domain. It turns the captured 16-bit RGB565 pixel stream into the 8-bit grey stream the edge detector consumes. Frame sync, line sync and the pixel strobe are carried through with matching latency.

## Interface
Parameters:
- `FRAME_DROP`, default 10: number of complete frames discarded after reset while the sensor settles.
- `H_PIXEL`, default 640: expected pixels per line (used only by the error check).
- `V_PIXEL`, default 480: expected lines per frame (used only by the error check).

Ports:
- `clk`, in, 1: pixel clock, driven from `cam_pclk`.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_frame_vsync`, in, 1: frame sync from capture, active high.
- `in_frame_href`, in, 1: line valid from capture.
- `in_frame_clken`, in, 1: pixel strobe; pixel valid when high.
- `in_img_rgb`, in, 16: pixel as {R[4:0], G[5:0], B[4:0]}.
- `out_frame_vsync`, out, 1: delayed, gated frame sync.
- `out_frame_href`, out, 1: delayed, gated line valid.
- `out_frame_clken`, out, 1: delayed, gated pixel strobe.
- `out_img_Y`, out, 8: luma.
- `out_frame_err`, out, 1: sticky geometry-error flag.

## Operation
- **Channel expansion (stage 1):** R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}. Register the products 77·R8, 150·G8 and 29·B8.
- **Sum (stage 2):** add the three products plus 128 for rounding, as a 17-bit sum. The maximum is 65408, so no overflow.
- **Output (stage 3):** `out_img_Y` = sum[15:8]. No saturation is needed because 77+150+29=256.
- **Frame counter:**
  - A rising edge is `in_frame_vsync`=1 with the previous sample 0.
  - Edges are numbered 1, 2, … after reset. The counter saturates once it reaches FRAME_DROP+1.
  - Width is $clog2(FRAME_DROP+2).
- **Pass state:**
  - `pass_en` resets to 0.
  - Output is enabled from the input cycle carrying rising edge FRAME_DROP+1, inclusive.
  - From then on `pass_en`=1 until reset.
  - The partial frame in flight at reset is always dropped. With FRAME_DROP=0, the first rising edge passes.
- **Gating:** while gated, vsync, href and clken entering stage 1 are forced to 0. Data still flows through the pipeline but is ignored.
- **Strobe handling:** the pipeline advances every clock regardless of clken. Non-clken beats carry don't-care Y.
- **Error check** (present only when the macro is defined, active only while `pass_en`=1):
  - `pix_cnt` counts clken while href=1.
  - On an href falling edge: compare `pix_cnt` with H_PIXEL, then clear `pix_cnt` and increment `line_cnt`.
  - On a vsync rising edge: compare `line_cnt` with V_PIXEL, then clear `line_cnt`.
  - Skip the vertical compare on the first passing rising edge.
  - Any mismatch sets `out_frame_err`, which stays set until reset.
- **Simultaneous events:** if an href falling edge and a vsync rising edge occur in the same cycle, the line counts toward the finishing frame before the vertical compare.

## Timing
- **Reset:** all outputs are 0, `pass_en`=0, and all counters are 0.
- **Reset mid-frame:** outputs drop to 0 asynchronously and the frame count restarts from edge 1.
- **Latency:** exactly 3 clocks from input to output for Y, vsync, href and clken. All four stay aligned cycle-for-cycle.
- **Throughput:** one pixel per clock, with no stall and no backpressure.
- **Error flag:** `out_frame_err` rises 1 clock after the input cycle carrying the offending edge.

## Configuration
- **`GRAY_GEOM_CHECK_EN` defined:** the pixel and line counters and the compare logic are built, and `out_frame_err` behaves as specified above.
- **Not defined:** the counters are absent and `out_frame_err` is tied to 0. Conversion and frame dropping are unchanged.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs 0. Release reset → outputs stay 0 until the pass condition is met.
- **Colour bars:** use FRAME_DROP=0 and a 640×480 frame of 16'hFFFF, 16'h0000, 16'hF800, 16'h07E0 and 16'h001F. Expect Y = 255, 0, 77, 149, 29, each exactly 3 clocks after its clken.
- **Frame drop:** use FRAME_DROP=2 and start reset mid-frame. Expect zero output through the partial frame and frames 1–2. Frame 3 appears with vsync, href and clken delayed by 3 clocks, and outputs continue uninterrupted after that.
- **Short line:** with the macro defined, send one line of 639 clken pixels → `out_frame_err`=1 one clock after the href falling edge, and it stays high through later correct frames.
- **Short frame:** with the macro defined, send a frame of 479 lines → `out_frame_err` sets one clock after the next vsync rising edge. The same stimulus with the macro undefined → `out_frame_err` stays 0.
- **Throughput:** send 640 back-to-back clken pixels in an incrementing pattern → 640 consecutive `out_frame_clken` pulses with no gaps and correct Y for each.
